// File: rtl/galaxian_audio_mix_if.sv
// Sample-side bundle between the galaxian sound outputs and the audio mixer.
// The master drives the channel bytes and controls; the slave (mixer) returns the stereo samples.
interface galaxian_audio_mix_if;
    logic [7:0]         audio_a;
    logic [7:0]         audio_b;
    logic [7:0]         audio_c;
    logic               dc_enable;
    logic [1:0]         volume;
    logic               mute;
    logic signed [15:0] sample_l;
    logic signed [15:0] sample_r;
    logic               sample_valid;
    logic               clip;

    // sample_valid is a one-cycle strobe with no backpressure; sample_l/r and clip
    // are meaningful on that cycle and hold their value until the next strobe.
    modport master (
        output audio_a, audio_b, audio_c, dc_enable, volume, mute,
        input  sample_l, sample_r, sample_valid, clip
    );

    modport slave (
        input  audio_a, audio_b, audio_c, dc_enable, volume, mute,
        output sample_l, sample_r, sample_valid, clip
    );
endinterface

// File: rtl/galaxian_audio_mix.sv
// Three-channel galaxian sound mixer: fixed-rate sampling, optional DC-blocking high-pass,
// gain, volume, mute and 16-bit saturation into an identical stereo pair.
module galaxian_audio_mix #(
    parameter int SAMPLE_DIV = 256,
    parameter int DC_SHIFT   = 8,
    parameter int GAIN_SHIFT = 5
) (
    input  logic                clk_sys,
    input  logic                reset,
    galaxian_audio_mix_if.slave aud
);
    localparam int              CW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic signed [17:0] Y_MAX = 18'sd32767;
    localparam logic signed [17:0] Y_MIN = -18'sd32767;
    localparam logic signed [23:0] S_MAX = 24'sd32767;
    localparam logic signed [23:0] S_MIN = -24'sd32768;

    logic [CW-1:0]      div_cnt_q, div_cnt_d;
    logic               tick;
    logic [10:0]        mix_q, mix_d;
    logic               s1_v_q, s1_v_d;
    logic [10:0]        x_prev_q, x_prev_d;
    logic signed [15:0] y_prev_q, y_prev_d;
    logic signed [15:0] y_q, y_d;
    logic               s2_v_q, s2_v_d;
    logic signed [15:0] sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               clip_q, clip_d;

    logic signed [17:0] x18, xp18, yp18, hp;
    logic signed [23:0] ext24, scaled, shifted;

    assign tick = (div_cnt_q == DIV_LAST);

    // Divider and stage 1: channel weights B*4 + C*2 + A, latched only on the sample tick.
    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + CW'(1);
        mix_d     = mix_q;
        if (tick) begin
            mix_d = {1'b0, aud.audio_b, 2'b00} + {2'b00, aud.audio_c, 1'b0} + {3'b000, aud.audio_a};
        end
        s1_v_d = tick;
    end

    // Stage 2: leaky high-pass y = x - x_prev + y_prev - y_prev/2^DC_SHIFT, or a fixed
    // mid-scale offset removal that also flushes the filter memory.
    always_comb begin
        x18      = signed'({7'd0, mix_q});
        xp18     = signed'({7'd0, x_prev_q});
        yp18     = {{2{y_prev_q[15]}}, y_prev_q};
        hp       = '0;
        y_d      = y_q;
        x_prev_d = x_prev_q;
        y_prev_d = y_prev_q;
        if (s1_v_q) begin
            x_prev_d = mix_q;
            if (aud.dc_enable) begin
                hp = x18 - xp18 + yp18 - (yp18 >>> DC_SHIFT);
                if (hp > Y_MAX) begin
                    y_d = Y_MAX[15:0];
                end else if (hp < Y_MIN) begin
                    y_d = Y_MIN[15:0];
                end else begin
                    y_d = hp[15:0];
                end
                y_prev_d = y_d;
            end else begin
                hp       = x18 - 18'sd1024;
                y_d      = hp[15:0];
                y_prev_d = '0;
            end
        end
        s2_v_d = s1_v_q;
    end

    // Stage 3: gain then volume attenuation at 24 bits, saturate; mute zeroes the sample and clip.
    always_comb begin
        ext24    = {{8{y_q[15]}}, y_q};
        scaled   = ext24 <<< GAIN_SHIFT;
        shifted  = scaled >>> aud.volume;
        sample_d = sample_q;
        clip_d   = 1'b0;
        valid_d  = s2_v_q;
        if (s2_v_q) begin
            if (shifted > S_MAX) begin
                sample_d = S_MAX[15:0];
                clip_d   = 1'b1;
            end else if (shifted < S_MIN) begin
                sample_d = S_MIN[15:0];
                clip_d   = 1'b1;
            end else begin
                sample_d = shifted[15:0];
            end
            if (aud.mute) begin
                sample_d = '0;
                clip_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_cnt_q <= '0;
            mix_q     <= '0;
            s1_v_q    <= 1'b0;
            x_prev_q  <= '0;
            y_prev_q  <= '0;
            y_q       <= '0;
            s2_v_q    <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mix_q     <= mix_d;
            s1_v_q    <= s1_v_d;
            x_prev_q  <= x_prev_d;
            y_prev_q  <= y_prev_d;
            y_q       <= y_d;
            s2_v_q    <= s2_v_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
        end
    end

    assign aud.sample_l     = sample_q;
    assign aud.sample_r     = sample_q;
    assign aud.sample_valid = valid_q;
    assign aud.clip         = clip_q;
endmodule

// File: tb/tb_galaxian_audio_mix.sv
// Directed-vector bench for galaxian_audio_mix: driver pushes hand-computed samples,
// a negedge monitor pops them on every sample_valid strobe.
module tb_galaxian_audio_mix;
    logic clk_sys = 1'b0;
    logic reset;

    galaxian_audio_mix_if aud ();

    galaxian_audio_mix dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .aud     (aud)
    );

    always #5 clk_sys = ~clk_sys;

    // {clip, sample}
    logic [16:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int first_valid_clk = 0;
    int last_valid_cyc = 0;
    int period = 0;

    // Clocks since reset was last sampled high; tick edges are the nonzero multiples of 256.
    always @(posedge clk_sys) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk_sys) begin
        logic [16:0] e;
        if (aud.sample_valid === 1'b1) begin
            // Registered on edge cyc, so a downstream flop captures it on edge cyc+1.
            if (valid_cnt == 0) first_valid_clk = cyc + 1;
            else                period = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            valid_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got sample=%0d clip=%0b, required no pulse",
                         $signed(aud.sample_l), aud.clip);
            end else begin
                e = exp_q.pop_front();
                if (aud.sample_l !== e[15:0] || aud.sample_r !== e[15:0] || aud.clip !== e[16]) begin
                    bad++;
                    $display("FAIL sample: got l=%0d r=%0d clip=%0b, required %0d clip=%0b",
                             $signed(aud.sample_l), $signed(aud.sample_r), aud.clip,
                             $signed(e[15:0]), e[16]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!(cyc != 0 && cyc % 256 == 0) && n < 400);
        if (n >= 400) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no tick in %0d clocks, required one within 256", n);
        end
    endtask

    task automatic drive(input int a, input int b, input int c, input logic dc,
                         input int vol, input logic mt, input int want, input logic want_clip);
        aud.audio_a   = 8'(a);
        aud.audio_b   = 8'(b);
        aud.audio_c   = 8'(c);
        aud.dc_enable = dc;
        aud.volume    = 2'(vol);
        aud.mute      = mt;
        exp_q.push_back({want_clip, 16'(want)});
        wait_tick();
        repeat (3) @(negedge clk_sys);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        aud.audio_a   = '0;
        aud.audio_b   = '0;
        aud.audio_c   = '0;
        aud.dc_enable = 1'b0;
        aud.volume    = '0;
        aud.mute      = 1'b0;
        repeat (4) @(negedge clk_sys);
        check("reset_sample_l", $signed(aud.sample_l), 0);
        check("reset_sample_r", $signed(aud.sample_r), 0);
        check("reset_valid", int'(aud.sample_valid), 0);
        check("reset_clip", int'(aud.clip), 0);
        reset = 1'b0;

        // Fixed offset removal: silence sits at full negative scale.
        drive(0, 0, 0, 1'b0, 0, 1'b0, -32768, 1'b0);
        check("first_valid_clock", first_valid_clk, 259);
        drive(0, 0, 0, 1'b0, 0, 1'b0, -32768, 1'b0);
        check("valid_period", period, 256);
        drive(255, 255, 255, 1'b0, 0, 1'b0, 24352, 1'b0);
        repeat (100) @(negedge clk_sys);
        check("hold_between_pulses", $signed(aud.sample_l), 24352);
        drive(255, 255, 255, 1'b0, 2, 1'b0, 6088, 1'b0);
        drive(0, 0, 0, 1'b0, 3, 1'b0, -4096, 1'b0);

        // High-pass step response on channel B, then release.
        drive(0, 0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
        drive(0, 255, 0, 1'b1, 0, 1'b0, 32640, 1'b0);
        drive(0, 255, 0, 1'b1, 0, 1'b0, 32544, 1'b0);
        drive(0, 255, 0, 1'b1, 0, 1'b0, 32448, 1'b0);
        drive(0, 0, 0, 1'b1, 0, 1'b0, -288, 1'b0);

        // Full-scale step saturates; mute suppresses sample and clip but not the filter.
        drive(0, 0, 0, 1'b0, 0, 1'b0, -32768, 1'b0);
        drive(255, 255, 255, 1'b1, 0, 1'b0, 32767, 1'b1);
        drive(0, 0, 0, 1'b0, 0, 1'b0, -32768, 1'b0);
        drive(255, 255, 255, 1'b1, 0, 1'b1, 0, 1'b0);
        drive(255, 255, 255, 1'b1, 0, 1'b0, 32767, 1'b1);
        drive(255, 255, 255, 1'b1, 1, 1'b0, 28368, 1'b0);
        drive(0, 0, 0, 1'b0, 0, 1'b0, -32768, 1'b0);

        // Reset one clock after a tick discards the in-flight sample.
        aud.audio_a = 8'd255;
        aud.audio_b = 8'd255;
        aud.audio_c = 8'd255;
        wait_tick();
        reset     = 1'b1;
        valid_cnt = 0;
        repeat (3) begin
            @(negedge clk_sys);
            check("rst_valid", int'(aud.sample_valid), 0);
            check("rst_sample", $signed(aud.sample_l), 0);
            check("rst_clip", int'(aud.clip), 0);
        end
        valid_cnt = 0;
        reset     = 1'b0;
        drive(255, 255, 255, 1'b0, 0, 1'b0, 24352, 1'b0);
        check("first_valid_after_reset", first_valid_clk, 259);

        repeat (10) @(negedge clk_sys);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
